ft60x_tx_master: RTL and testbench

FT600/FT601 245-synchronous-FIFO write master in the CLK_FTDI domain. Pulls 32-bit words from the read side of the CDC FIFO, which is filled from the CLK_FPGA domain, and drives WR_N, DATA and BE to the FT60x pins under TXE_N flow control. Sits between the async FIFO and the top-level pad/tri-state logic that `top` instantiates.

---
 rtl/ft60x_pkg.sv | 13 +
 rtl/ft60x_skid_buf.sv | 56 +++++
 rtl/ft60x_tx_master.sv | 144 ++++++++++++++
 tb/tb_ft60x_tx_master.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ft60x_pkg.sv
// Shared definitions for the FT60x 245-sync-FIFO write master.
package ft60x_pkg;

    localparam int FT60X_DATA_W = 32;
    localparam int FT60X_BE_W   = FT60X_DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_e;

endpackage

// File: rtl/ft60x_skid_buf.sv
// Two-entry prefetch/skid buffer. The head register is presented on out_data_o,
// the skid register catches the word already in flight while the head stalls.
module ft60x_skid_buf #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    input  logic         out_ready_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] head_q, skid_q;
    logic [1:0]   cnt_q;
    logic         push, pop;

    assign push        = in_valid_i;
    assign pop         = out_ready_i && (cnt_q != 2'd0);
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = head_q;
    assign count_o     = cnt_q;

    // The producer never pushes into a full buffer unless it is popping too.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= '0;
            skid_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= in_data_i;
                    else               skid_q <= in_data_i;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    if (cnt_q == 2'd2) head_q <= skid_q;
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        head_q <= skid_q;
                        skid_q <= in_data_i;
                    end else begin
                        head_q <= in_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ft60x_tx_master.sv
// FT600/FT601 write master: drains the CDC FIFO into the FT60x under TXE_N.
// Define FT60X_TEST_PATTERN_EN to source an incrementing counter instead of the FIFO.
module ft60x_tx_master
    import ft60x_pkg::*;
#(
    parameter int DATA_W    = FT60X_DATA_W,
    parameter int MAX_BURST = 1024
) (
    input  logic                CLK_FTDI,
    input  logic                rst,
    input  logic                fifo_empty,
    output logic                fifo_rd_en,
    input  logic [DATA_W-1:0]   fifo_dout,
    input  logic                TXE_N,
    output logic                WR_N,
    output logic [DATA_W-1:0]   DATA,
    output logic                DATA_OE,
    output logic [DATA_W/8-1:0] BE,
    output logic                RD_N,
    output logic                OE_N,
    output logic [31:0]         tx_count
);

    localparam int BE_W = DATA_W / 8;

    tx_state_e         state_q;
    logic              wr_n_q, oe_q, rd_vld_q;
    logic [BE_W-1:0]   be_q;
    logic [16:0]       burst_q;
    logic [31:0]       tx_cnt_q;

    logic              accept, src_avail, fetch, buf_vld;
    logic [1:0]        buf_cnt;
    logic [2:0]        occ_after;
    logic [DATA_W-1:0] in_data;

    assign accept    = !wr_n_q && !TXE_N;
    // Words left in the buffer after this edge, counting the pop already in flight.
    assign occ_after = {1'b0, buf_cnt} - {2'b0, accept} + {2'b0, rd_vld_q};
    assign fetch     = src_avail && !rst && (occ_after < 3'd2);

`ifdef FT60X_TEST_PATTERN_EN
    logic [DATA_W-1:0] pat_cnt_q, pat_dat_q;
    logic              unused_fifo;

    // Counter advances per fetched word; every fetched word is sent, so the
    // accepted sequence is 0,1,2,...
    always_ff @(posedge CLK_FTDI) begin
        if (rst) begin
            pat_cnt_q <= '0;
            pat_dat_q <= '0;
        end else if (fetch) begin
            pat_dat_q <= pat_cnt_q;
            pat_cnt_q <= pat_cnt_q + 1'b1;
        end
    end

    assign src_avail   = 1'b1;
    assign in_data     = pat_dat_q;
    assign fifo_rd_en  = 1'b0;
    assign unused_fifo = ^{fifo_empty, fifo_dout};
`else
    assign src_avail  = !fifo_empty;
    assign in_data    = fifo_dout;
    assign fifo_rd_en = fetch;
`endif

    ft60x_skid_buf #(.W(DATA_W)) u_buf (
        .clk_i       (CLK_FTDI),
        .rst_i       (rst),
        .in_valid_i  (rd_vld_q),
        .in_data_i   (in_data),
        .out_ready_i (accept),
        .out_valid_o (buf_vld),
        .out_data_o  (DATA),
        .count_o     (buf_cnt)
    );

    always_ff @(posedge CLK_FTDI) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_n_q   <= 1'b1;
            be_q     <= '0;
            oe_q     <= 1'b0;
            burst_q  <= '0;
            tx_cnt_q <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            rd_vld_q <= fetch;
            if (accept) tx_cnt_q <= tx_cnt_q + 32'd1;
            unique case (state_q)
                ST_IDLE: begin
                    if (buf_vld && !TXE_N) begin
                        state_q <= ST_BURST;
                        wr_n_q  <= 1'b0;
                        be_q    <= '1;
                        oe_q    <= 1'b1;
                    end
                end
                ST_BURST: begin
                    if (accept) begin
                        burst_q <= burst_q + 17'd1;
                        if (burst_q + 17'd1 == 17'(MAX_BURST)) begin
                            state_q <= ST_GAP;
                            wr_n_q  <= 1'b1;
                            be_q    <= '0;
                        end else if (occ_after == 3'd0) begin
                            state_q <= ST_IDLE;
                            wr_n_q  <= 1'b1;
                            be_q    <= '0;
                            oe_q    <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    // Pass through IDLE within the same edge so the gap is one cycle.
                    burst_q <= '0;
                    if (buf_vld && !TXE_N) begin
                        state_q <= ST_BURST;
                        wr_n_q  <= 1'b0;
                        be_q    <= '1;
                    end else begin
                        state_q <= ST_IDLE;
                        oe_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    wr_n_q  <= 1'b1;
                    be_q    <= '0;
                    oe_q    <= 1'b0;
                end
            endcase
        end
    end

    assign WR_N     = wr_n_q;
    assign BE       = be_q;
    assign DATA_OE  = oe_q;
    assign RD_N     = 1'b1;
    assign OE_N     = 1'b1;
    assign tx_count = tx_cnt_q;

endmodule

// File: tb/tb_ft60x_tx_master.sv
// Directed bench for ft60x_tx_master: one instance with the default burst limit,
// one with MAX_BURST=4, each fed by a small behavioural FIFO.
module tb_ft60x_tx_master;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: MAX_BURST default
    logic        a_empty, a_rd, a_txe, a_wrn, a_oe, a_rdn, a_oen;
    logic [31:0] a_dout = '0;
    logic [31:0] a_data, a_cnt;
    logic [3:0]  a_be;
    logic [31:0] a_mem [0:63];
    int          a_wp = 0, a_rp = 0;

    assign a_empty = (a_wp == a_rp);
    always @(posedge clk)
        if (a_rd && !a_empty) begin
            a_dout <= a_mem[a_rp];
            a_rp   <= a_rp + 1;
        end

    // Instance B: MAX_BURST = 4
    logic        b_empty, b_rd, b_txe, b_wrn, b_oe, b_rdn, b_oen;
    logic [31:0] b_dout = '0;
    logic [31:0] b_data, b_cnt;
    logic [3:0]  b_be;
    logic [31:0] b_mem [0:15];
    int          b_wp = 0, b_rp = 0;

    assign b_empty = (b_wp == b_rp);
    always @(posedge clk)
        if (b_rd && !b_empty) begin
            b_dout <= b_mem[b_rp];
            b_rp   <= b_rp + 1;
        end

    ft60x_tx_master dut_a (
        .CLK_FTDI(clk), .rst(rst), .fifo_empty(a_empty), .fifo_rd_en(a_rd),
        .fifo_dout(a_dout), .TXE_N(a_txe), .WR_N(a_wrn), .DATA(a_data),
        .DATA_OE(a_oe), .BE(a_be), .RD_N(a_rdn), .OE_N(a_oen), .tx_count(a_cnt)
    );

    ft60x_tx_master #(.MAX_BURST(4)) dut_b (
        .CLK_FTDI(clk), .rst(rst), .fifo_empty(b_empty), .fifo_rd_en(b_rd),
        .fifo_dout(b_dout), .TXE_N(b_txe), .WR_N(b_wrn), .DATA(b_data),
        .DATA_OE(b_oe), .BE(b_be), .RD_N(b_rdn), .OE_N(b_oen), .tx_count(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [31:0] v);
        a_mem[a_wp] = v;
        a_wp++;
    endtask

    task automatic push_b(input logic [31:0] v);
        b_mem[b_wp] = v;
        b_wp++;
    endtask

    task automatic wait_a_low(input string tag);
        int n = 0;
        while (a_wrn !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'b0, a_wrn}, 32'd0);
    endtask

    logic [0:12] exp_wr;
    logic [31:0] exp_v;
    int          n;

    initial begin
        rst   = 1'b1;
        a_txe = 1'b1;
        b_txe = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wrn",  {31'b0, a_wrn}, 32'd1);
        chk("rst_rdn",  {31'b0, a_rdn}, 32'd1);
        chk("rst_oen",  {31'b0, a_oen}, 32'd1);
        chk("rst_data", a_data, 32'd0);
        chk("rst_be",   {28'b0, a_be}, 32'd0);
        chk("rst_oe",   {31'b0, a_oe}, 32'd0);
        chk("rst_rd",   {31'b0, a_rd}, 32'd0);
        chk("rst_cnt",  a_cnt, 32'd0);
        chk("rst_b_wrn", {31'b0, b_wrn}, 32'd1);
        chk("rst_b_cnt", b_cnt, 32'd0);
        rst = 1'b0;

`ifdef FT60X_TEST_PATTERN_EN
        a_txe = 1'b0;
        exp_v = 32'd0;
        repeat (300) begin
            @(negedge clk);
            chk("pat_rd", {31'b0, a_rd}, 32'd0);
            if (a_wrn === 1'b0) begin
                chk("pat_data", a_data, exp_v);
                exp_v = exp_v + 32'd1;
            end
        end
        chk("pat_thru", {31'b0, exp_v >= 32'd290}, 32'd1);
`else
        // Streaming: 16 words preloaded while TXE_N is high
        for (int i = 1; i <= 16; i++) push_a(32'(i));
        repeat (3) @(negedge clk);
        chk("stall_idle", {31'b0, a_wrn}, 32'd1);
        a_txe = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 16; i++) begin
            chk("strm_wrn",  {31'b0, a_wrn}, 32'd0);
            chk("strm_data", a_data, 32'(i));
            chk("strm_be",   {28'b0, a_be}, 32'hF);
            @(negedge clk);
        end
        chk("strm_end_wrn", {31'b0, a_wrn}, 32'd1);
        chk("strm_cnt",     a_cnt, 32'd16);
        chk("strm_end_oe",  {31'b0, a_oe}, 32'd0);

        // First-word latency and underflow after 3 words
        push_a(32'hA1); push_a(32'hA2); push_a(32'hA3);
        @(negedge clk); chk("lat_c1", {31'b0, a_wrn}, 32'd1);
        @(negedge clk); chk("lat_c2", {31'b0, a_wrn}, 32'd1);
        @(negedge clk); chk("lat_c3", {31'b0, a_wrn}, 32'd0);
        chk("uf_w1", a_data, 32'hA1);
        chk("uf_oe", {31'b0, a_oe}, 32'd1);
        @(negedge clk); chk("uf_w2", a_data, 32'hA2);
        @(negedge clk); chk("uf_w3", a_data, 32'hA3);
        chk("uf_w3_wrn", {31'b0, a_wrn}, 32'd0);
        @(negedge clk);
        chk("uf_wrn", {31'b0, a_wrn}, 32'd1);
        chk("uf_oe0", {31'b0, a_oe}, 32'd0);
        chk("uf_be0", {28'b0, a_be}, 32'd0);
        chk("uf_cnt", a_cnt, 32'd19);

        // Backpressure: stall 5 cycles with word 5 presented
        for (int i = 1; i <= 8; i++) push_a(32'(i));
        n = 0;
        while (!(a_wrn === 1'b0 && a_data === 32'd5) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach", a_data, 32'd5);
        a_txe = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_wrn",  {31'b0, a_wrn}, 32'd0);
            chk("bp_hold_data", a_data, 32'd5);
            chk("bp_hold_be",   {28'b0, a_be}, 32'hF);
        end
        a_txe = 1'b0;
        @(negedge clk); chk("bp_w6", a_data, 32'd6);
        chk("bp_w6_wrn", {31'b0, a_wrn}, 32'd0);
        @(negedge clk); chk("bp_w7", a_data, 32'd7);
        @(negedge clk); chk("bp_w8", a_data, 32'd8);
        @(negedge clk);
        chk("bp_end_wrn", {31'b0, a_wrn}, 32'd1);
        chk("bp_cnt", a_cnt, 32'd27);

        // Burst limit on the MAX_BURST=4 instance
        for (int i = 0; i < 10; i++) push_b(32'h101 + 32'(i));
        repeat (3) @(negedge clk);
        b_txe  = 1'b0;
        exp_wr = 13'b0000_1_0000_1_00_1;
        exp_v  = 32'h101;
        @(negedge clk);
        for (int k = 0; k < 13; k++) begin
            chk("bl_wrn", {31'b0, b_wrn}, {31'b0, exp_wr[k]});
            if (exp_wr[k] == 1'b0) begin
                chk("bl_data", b_data, exp_v);
                exp_v = exp_v + 32'd1;
            end
            @(negedge clk);
        end
        chk("bl_cnt", b_cnt, 32'd10);

        // Reset in the middle of an active burst
        for (int i = 1; i <= 6; i++) push_a(32'h50 + 32'(i));
        wait_a_low("mr_wait");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mr_wrn",  {31'b0, a_wrn}, 32'd1);
        chk("mr_data", a_data, 32'd0);
        chk("mr_be",   {28'b0, a_be}, 32'd0);
        chk("mr_cnt",  a_cnt, 32'd0);
        chk("mr_rd",   {31'b0, a_rd}, 32'd0);
        chk("mr_oe",   {31'b0, a_oe}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
